// File: rtl/rca_operand_loader_pkg.sv
// Shared constants, helpers and state encoding for the RCA operand loader.
package rca_operand_loader_pkg;

    // Default register latency of the bound ripple-carry adder (input reg + output reg).
    localparam int unsigned ADD_LAT_DEF = 2;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } ld_state_e;

    // Number of stream beats per operand.
    function automatic int unsigned calc_beats(input int unsigned n, input int unsigned w);
        return n / w;
    endfunction

    // Width of the beat counter spanning one full A+B frame.
    function automatic int unsigned calc_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(2 * beats) : 1;
    endfunction

    // Width of the word index within one operand.
    function automatic int unsigned calc_idx_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/rca_operand_loader_if.sv
// Narrow valid/ready operand stream feeding the loader.
interface rca_operand_loader_if #(
    parameter int unsigned W = 32
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/rca_lat_tracker.sv
// Tracks the fixed latency of a registered adder: issue, busy and add_done pulses.
module rca_lat_tracker
    import rca_operand_loader_pkg::*;
#(
    parameter int unsigned ADD_LAT = ADD_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic issue,
    output logic add_done,
    output logic busy
);

    // sr[k] is high k cycles after the issue cycle; sr[ADD_LAT] marks the result cycle.
    logic [ADD_LAT:0] sr;

    // Shift the issue token and hold busy from the issue cycle until the result cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            busy <= 1'b0;
        end else begin
            sr   <= {sr[ADD_LAT-1:0], go};
            busy <= go | (busy & ~sr[ADD_LAT-1]);
        end
    end

    assign issue    = sr[0];
    assign add_done = sr[ADD_LAT];

endmodule

// File: rtl/rca_operand_loader.sv
// Collects A and B operands from a W-bit stream, then issues them to a registered adder.
module rca_operand_loader
    import rca_operand_loader_pkg::*;
#(
    parameter int unsigned N       = 1024,
    parameter int unsigned W       = 32,
    parameter int unsigned ADD_LAT = ADD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rca_operand_loader_if.slave  stream,
    output logic [N-1:0]         a_out,
    output logic [N-1:0]         b_out,
    output logic                 issue,
    output logic                 add_done,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int unsigned BEATS = calc_beats(N, W);
    localparam int unsigned CNT_W = calc_cnt_w(BEATS);
    localparam int unsigned IDX_W = calc_idx_w(BEATS);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * BEATS - 1);
    localparam logic [CNT_W-1:0] B_BASE   = CNT_W'(BEATS);

    ld_state_e                 state;
    logic [CNT_W-1:0]          bcnt;
    logic [BEATS-1:0][W-1:0]   shadow_a;
    logic [BEATS-1:0][W-1:0]   shadow_b;
    logic                      ready_q;

    logic                      accept_c;
    logic                      last_beat_c;
    logic                      is_a_c;
    logic [IDX_W-1:0]          widx_c;
    logic                      go_c;

    assign stream.in_ready = ready_q;

    // Beat decode: which operand and word the current beat lands in.
    assign accept_c    = stream.in_valid & ready_q;
    assign last_beat_c = (bcnt == LAST_CNT);
    assign is_a_c      = (bcnt < B_BASE);
    assign widx_c      = is_a_c ? IDX_W'(bcnt) : IDX_W'(bcnt - B_BASE);

    // A full shadow may issue once the adder is idle or delivering its result.
    assign go_c = (state == ST_FULL) & (~busy | add_done);

    // Frame fill / issue state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            bcnt      <= '0;
            shadow_a  <= '0;
            shadow_b  <= '0;
            a_out     <= '0;
            b_out     <= '0;
            ready_q   <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept_c) begin
                        if (stream.in_last != last_beat_c) begin
                            frame_err <= 1'b1;
                            bcnt      <= '0;
                        end else begin
                            if (is_a_c) begin
                                shadow_a[widx_c] <= stream.in_data;
                            end else begin
                                shadow_b[widx_c] <= stream.in_data;
                            end
                            if (last_beat_c) begin
                                state   <= ST_FULL;
                                ready_q <= 1'b0;
                                bcnt    <= '0;
                            end else begin
                                bcnt <= bcnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (go_c) begin
                        a_out   <= shadow_a;
                        b_out   <= shadow_b;
                        state   <= ST_FILL;
                        ready_q <= 1'b1;
                        bcnt    <= '0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    rca_lat_tracker #(
        .ADD_LAT (ADD_LAT)
    ) u_lat_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go_c),
        .issue    (issue),
        .add_done (add_done),
        .busy     (busy)
    );

endmodule

// File: tb/tb_rca_operand_loader.sv
// Directed bench for rca_operand_loader with a registered adder model on its outputs.
module tb_rca_operand_loader;

    localparam int unsigned N     = 64;
    localparam int unsigned W     = 16;
    localparam int unsigned BEATS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca_operand_loader_if #(.W(W)) sif ();

    logic [N-1:0] a_out;
    logic [N-1:0] b_out;
    logic         issue;
    logic         add_done;
    logic         busy;
    logic         frame_err;

    rca_operand_loader #(
        .N       (N),
        .W       (W),
        .ADD_LAT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stream    (sif),
        .a_out     (a_out),
        .b_out     (b_out),
        .issue     (issue),
        .add_done  (add_done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Registered ripple-carry adder bound to the loader outputs (input reg + output reg).
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N:0]   add_sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a   <= '0;
            add_b   <= '0;
            add_sum <= '0;
        end else begin
            add_a   <= a_out;
            add_b   <= b_out;
            add_sum <= {1'b0, add_a} + {1'b0, add_b};
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] q_a[$];
    logic [N-1:0] q_b[$];
    logic [N:0]   q_sum[$];
    logic [N:0]   pend_sum[$];
    int           pend_cyc[$];
    int           n_issue = 0;
    int           n_done = 0;
    int           n_ferr = 0;
    int           last_issue_cyc = 0;
    int           final_acc_cyc = 0;
    bit           have_issue = 1'b0;
    bit           exp_full = 1'b0;
    bit           mon_en = 1'b0;
    logic [N-1:0] prev_a = '0;
    logic [N-1:0] prev_b = '0;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Protocol monitor: issue contents, result latency/value, busy, hold and ready.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (add_done) begin
                if (pend_sum.size() == 0) begin
                    chk_eq("done_unexpected", 128'(1), 128'(0));
                end else begin
                    chk_eq("done_latency", 128'(cyc - pend_cyc[0]), 128'(2));
                    chk_eq("sum", 128'(add_sum), 128'(pend_sum[0]));
                    void'(pend_sum.pop_front());
                    void'(pend_cyc.pop_front());
                end
                n_done++;
            end
            if (issue) begin
                chk_eq("issue_overlap", 128'(pend_sum.size()), 128'(0));
                if (q_a.size() == 0) begin
                    chk_eq("issue_unexpected", 128'(1), 128'(0));
                end else begin
                    chk_eq("a_out", 128'(a_out), 128'(q_a[0]));
                    chk_eq("b_out", 128'(b_out), 128'(q_b[0]));
                    pend_sum.push_back(q_sum[0]);
                    pend_cyc.push_back(cyc);
                    void'(q_a.pop_front());
                    void'(q_b.pop_front());
                    void'(q_sum.pop_front());
                end
                exp_full       = 1'b0;
                have_issue     = 1'b1;
                last_issue_cyc = cyc;
                n_issue++;
            end else begin
                chk_eq("a_hold", 128'(a_out), 128'(prev_a));
                chk_eq("b_hold", 128'(b_out), 128'(prev_b));
            end
            prev_a = a_out;
            prev_b = b_out;
            chk_eq("busy", 128'(busy), 128'(have_issue && ((cyc - last_issue_cyc) < 2)));
            chk_eq("in_ready", 128'(sif.in_ready), 128'(!exp_full));
            if (frame_err) n_ferr++;
        end
    end

    task automatic idle_in();
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
        sif.in_data  = '0;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        idle_in();
        q_a.delete();
        q_b.delete();
        q_sum.delete();
        pend_sum.delete();
        pend_cyc.delete();
        exp_full   = 1'b0;
        have_issue = 1'b0;
        prev_a     = '0;
        prev_b     = '0;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Send nbeats beats; bad_pos < 0 is a legal frame, otherwise in_last sits on beat bad_pos only.
    task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N:0] exp_sum,
                              input int bad_pos, input int nbeats, input bit rnd, input int stall);
        bit good;
        bit acc;
        good = (bad_pos < 0);
        if (good) begin
            q_a.push_back(a);
            q_b.push_back(b);
            q_sum.push_back(exp_sum);
        end
        for (int k = 0; k < nbeats; k++) begin
            if (rnd && ($urandom_range(1) == 0)) begin
                sif.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            if ((k == nbeats - 1) && (stall > 0)) begin
                sif.in_valid = 1'b0;
                repeat (stall) @(posedge clk);
                #1;
            end
            sif.in_data  = (k < BEATS) ? a[k*W +: W] : b[(k-BEATS)*W +: W];
            sif.in_last  = good ? (k == 2*BEATS - 1) : (k == bad_pos);
            sif.in_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; (t < 100) && !acc; t++) begin
                acc = sif.in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) chk_eq("beat_timeout", 128'(0), 128'(1));
        end
        final_acc_cyc = cyc;
        if (good) exp_full = 1'b1;
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; (t < 300) && (n_done < target); t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("done_count", 128'(n_done), 128'(target));
    endtask

    localparam logic [N-1:0] A2 = 64'h0004_0003_0002_0001;
    localparam logic [N-1:0] B2 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [N:0]   S2 = 65'h1_0004_0003_0002_0000;

    initial begin
        int ferr0;
        idle_in();
        assert_reset();
        release_reset();
        mon_en = 1'b1;

        // Idle after reset.
        repeat (20) begin
            @(negedge clk);
            chk_eq("idle_flags", 128'({sif.in_ready, issue, add_done, busy, frame_err}), 128'(5'b10000));
            chk_eq("idle_ab", 128'({a_out, b_out}), 128'(0));
        end
        @(posedge clk);
        #1;

        // Single frame with wrap-around carry.
        send_frame(A2, B2, S2, -1, 8, 1'b0, 0);
        idle_in();
        wait_done(1);
        chk_eq("issue_latency", 128'(last_issue_cyc - final_acc_cyc), 128'(1));

        // Back-to-back frames with in_valid held high.
        send_frame(64'h1, 64'h1, 65'h0_0000_0000_0000_0002, -1, 8, 1'b0, 0);
        send_frame(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 65'h0_8000_0000_0000_0000, -1, 8, 1'b0, 0);
        idle_in();
        wait_done(3);
        chk_eq("issue_count_b2b", 128'(n_issue), 128'(3));

        // Early in_last, then missing in_last, then a clean frame.
        ferr0 = n_ferr;
        send_frame(64'h0, 64'h0, 65'h0, 3, 4, 1'b0, 0);
        idle_in();
        chk_eq("ferr_early_pulse", 128'(frame_err), 128'(1));
        @(posedge clk);
        #1;
        chk_eq("ferr_early_clear", 128'(frame_err), 128'(0));
        send_frame(64'h0, 64'h0, 65'h0, 8, 8, 1'b0, 0);
        idle_in();
        chk_eq("ferr_late_pulse", 128'(frame_err), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        chk_eq("ferr_count", 128'(n_ferr - ferr0), 128'(2));
        chk_eq("ferr_no_issue", 128'(n_issue), 128'(3));
        send_frame(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 65'h0_2222_2222_2222_2211,
                   -1, 8, 1'b0, 0);
        idle_in();
        wait_done(4);

        // Random valid gaps plus a long stall before the final beat.
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE,
                   -1, 8, 1'b1, 30);
        send_frame(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000,
                   -1, 8, 1'b1, 30);
        idle_in();
        wait_done(6);
        repeat (20) @(posedge clk);
        #1;
        chk_eq("rand_done_count", 128'(n_done), 128'(6));
        chk_eq("rand_issue_count", 128'(n_issue), 128'(6));

        // Reset one cycle after issue discards the add in flight.
        send_frame(64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111, 65'h0_6666_6666_6666_6666,
                   -1, 8, 1'b0, 0);
        idle_in();
        for (int t = 0; (t < 100) && (n_issue < 7); t++) @(posedge clk);
        #1;
        chk_eq("rst_issue_seen", 128'(n_issue), 128'(7));
        assert_reset();
        #1;
        chk_eq("rst_ab", 128'({a_out, b_out}), 128'(0));
        chk_eq("rst_flags", 128'({sif.in_ready, issue, add_done, busy, frame_err}), 128'(5'b10000));
        release_reset();
        repeat (10) @(posedge clk);
        #1;
        chk_eq("rst_no_done", 128'(n_done), 128'(6));
        send_frame(A2, B2, S2, -1, 8, 1'b0, 0);
        idle_in();
        wait_done(7);
        chk_eq("post_rst_latency", 128'(last_issue_cyc - final_acc_cyc), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
